// File: rtl/dump_trig_ctrl.sv
// dump_trig_ctrl
// Trigger and sequencing controller for the debug dump capture buffer.
// Samples circulate through the buffer while armed (PRE). A pattern match,
// or an immediate arm, starts the post-trigger phase (POST). After the
// programmed number of post-trigger samples has been written, capture
// stops (DONE).
//
// Ports
//   clk, rst_        system clock, asynchronous active-low reset
//   vld, dat         incoming sample stream
//   cap_we/wa/wd     registered write port into the capture RAM
//   cap_busy         high while in PRE or POST
//   upen/upa/upws/uprs/updi/updo/uprdy
//                    CPU register bus; uprdy pulses the cycle after an access
//
// Register map (upa)
//   0 CTRL     W: bit0 ARM, bit1 MODE (1 = pattern trigger), bit2 ABORT
//              R: MODE in bit1
//   1 STAT     R: [1:0] state, bit2 WRAPPED, bit3 TRIGGERED
//   2 PATTERN  RW
//   3 MASK     RW (a set bit takes part in the compare; 0 matches all)
//   4 POSTCNT  RW, low DBADD bits
//   5 TRIGADDR R
//   6 WRPTR    R
//   7 -        reads 0
module dump_trig_ctrl #(
    parameter int DBADD = 11,
    parameter int DBDAT = 32
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             vld,
    input  logic [DBDAT-1:0] dat,
    output logic             cap_we,
    output logic [DBADD-1:0] cap_wa,
    output logic [DBDAT-1:0] cap_wd,
    output logic             cap_busy,
    input  logic             upen,
    input  logic [2:0]       upa,
    input  logic             upws,
    input  logic             uprs,
    input  logic [DBDAT-1:0] updi,
    output logic [DBDAT-1:0] updo,
    output logic             uprdy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        POST = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STAT     = 3'd1;
    localparam logic [2:0] REG_PATTERN  = 3'd2;
    localparam logic [2:0] REG_MASK     = 3'd3;
    localparam logic [2:0] REG_POSTCNT  = 3'd4;
    localparam logic [2:0] REG_TRIGADDR = 3'd5;
    localparam logic [2:0] REG_WRPTR    = 3'd6;

    // One extra bit so an immediate arm can load POSTCNT+1 without overflow.
    localparam logic [DBADD:0] PL_ONE = (DBADD + 1)'(1);

    state_t           state, state_next;
    logic             mode;
    logic [DBDAT-1:0] pattern;
    logic [DBDAT-1:0] mask;
    logic [DBADD-1:0] postcnt_cfg;
    logic [DBADD-1:0] wrptr;
    logic [DBADD-1:0] trigaddr;
    logic             wrapped;
    logic             triggered;
    logic [DBADD:0]   post_left;

    logic             cpu_wr, cpu_rd, ctrl_wr;
    logic             arm, abort, arm_mode;
    logic             match;
    logic             capture, hit;
    logic [DBDAT-1:0] rd_data;

    // A simultaneous read and write strobe is treated as a write.
    assign cpu_wr   = upen & upws;
    assign cpu_rd   = upen & uprs & ~upws;
    assign ctrl_wr  = cpu_wr && (upa == REG_CTRL);
    assign abort    = ctrl_wr & updi[2];
    assign arm      = ctrl_wr & updi[0] & ~updi[2];
    // The MODE written together with ARM selects how this arm behaves.
    assign arm_mode = updi[1];
    assign match    = vld && (((dat ^ pattern) & mask) == '0);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            cap_busy <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state    <= state_next;
            cap_busy <= (state_next == PRE) || (state_next == POST);
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_next = state;
        capture    = 1'b0;
        hit        = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else if (arm) begin
            state_next = arm_mode ? PRE : POST;
        end else begin
            unique case (state)
                PRE: begin
                    if (vld) begin
                        capture = 1'b1;
                        if (match) begin
                            hit        = 1'b1;
                            state_next = (postcnt_cfg == '0) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    if (vld) begin
                        capture = 1'b1;
                        // The sample that brings the count to zero is the last.
                        if (post_left <= PL_ONE) begin
                            state_next = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------- capture datapath
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cap_we    <= 1'b0;
            cap_wa    <= '0;
            cap_wd    <= '0;
            wrptr     <= '0;
            trigaddr  <= '0;
            wrapped   <= 1'b0;
            triggered <= 1'b0;
            post_left <= '0;
        end else begin
            cap_we <= capture;
            if (capture) begin
                cap_wa <= wrptr;
                cap_wd <= dat;
            end

            if (arm) begin
                wrptr     <= '0;
                wrapped   <= 1'b0;
                trigaddr  <= '0;
                // An immediate arm is its own trigger at address 0.
                triggered <= ~arm_mode;
                post_left <= {1'b0, postcnt_cfg} + PL_ONE;
            end else if (capture) begin
                wrptr <= wrptr + DBADD'(1);
                if (&wrptr) begin
                    wrapped <= 1'b1;
                end
                if (hit) begin
                    triggered <= 1'b1;
                    trigaddr  <= wrptr;
                    // The trigger sample itself is not counted.
                    post_left <= {1'b0, postcnt_cfg};
                end else if (state == POST) begin
                    post_left <= post_left - PL_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------- CPU registers
    always_comb begin
        rd_data = '0;
        unique case (upa)
            REG_CTRL:     rd_data = DBDAT'({mode, 1'b0});
            REG_STAT:     rd_data = DBDAT'({triggered, wrapped, state});
            REG_PATTERN:  rd_data = pattern;
            REG_MASK:     rd_data = mask;
            REG_POSTCNT:  rd_data = DBDAT'(postcnt_cfg);
            REG_TRIGADDR: rd_data = DBDAT'(trigaddr);
            REG_WRPTR:    rd_data = DBDAT'(wrptr);
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mode        <= 1'b0;
            pattern     <= '0;
            mask        <= '0;
            postcnt_cfg <= '0;
            updo        <= '0;
            uprdy       <= 1'b0;
        end else begin
            uprdy <= upen & (upws | uprs);
            if (cpu_rd) begin
                updo <= rd_data;
            end
            if (cpu_wr) begin
                unique case (upa)
                    REG_CTRL:    mode        <= updi[1];
                    REG_PATTERN: pattern     <= updi;
                    REG_MASK:    mask        <= updi;
                    REG_POSTCNT: postcnt_cfg <= updi[DBADD-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dump_trig_ctrl.sv
// tb_dump_trig_ctrl
// Directed bench for dump_trig_ctrl. Stimulus tasks push the expected CPU
// responses and capture writes into queues; monitors on the falling edge
// pop and compare whenever the DUT presents uprdy or cap_we.
module tb_dump_trig_ctrl;

    localparam int DBADD = 11;
    localparam int DBDAT = 32;

    logic             clk  = 1'b0;
    logic             rst_ = 1'b0;
    logic             vld  = 1'b0;
    logic [DBDAT-1:0] dat  = '0;
    logic             upen = 1'b0;
    logic [2:0]       upa  = '0;
    logic             upws = 1'b0;
    logic             uprs = 1'b0;
    logic [DBDAT-1:0] updi = '0;

    logic             cap_we;
    logic [DBADD-1:0] cap_wa;
    logic [DBDAT-1:0] cap_wd;
    logic             cap_busy;
    logic [DBDAT-1:0] updo;
    logic             uprdy;

    dump_trig_ctrl #(.DBADD(DBADD), .DBDAT(DBDAT)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .vld      (vld),
        .dat      (dat),
        .cap_we   (cap_we),
        .cap_wa   (cap_wa),
        .cap_wd   (cap_wd),
        .cap_busy (cap_busy),
        .upen     (upen),
        .upa      (upa),
        .upws     (upws),
        .uprs     (uprs),
        .updi     (updi),
        .updo     (updo),
        .uprdy    (uprdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_rd;
        int          rg;
        logic [31:0] data;
        int          cyc;
    } cpu_exp_t;

    typedef struct {
        logic [DBADD-1:0] addr;
        logic [DBDAT-1:0] data;
    } cap_exp_t;

    cpu_exp_t cpu_q[$];
    cap_exp_t cap_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------------------------------------------------- monitors
    always @(negedge clk) begin
        cpu_exp_t ce;
        cap_exp_t ke;
        if (rst_) begin
            if (uprdy) begin
                if (cpu_q.size() == 0) begin
                    check("uprdy_unexpected", 32'd1, 32'd0);
                end else begin
                    ce = cpu_q.pop_front();
                    check($sformatf("uprdy_cycle_reg%0d", ce.rg), cyc, ce.cyc + 1);
                    if (ce.is_rd) check($sformatf("read_reg%0d", ce.rg), updo, ce.data);
                end
            end
            if (cap_we) begin
                if (cap_q.size() == 0) begin
                    check("cap_we_unexpected", {21'd0, cap_wa}, 32'hFFFF_FFFF);
                end else begin
                    ke = cap_q.pop_front();
                    check("cap_wa", {21'd0, cap_wa}, {21'd0, ke.addr});
                    check("cap_wd", cap_wd, ke.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------- stimulus
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [31:0] d);
        upen = 1'b1; upws = 1'b1; upa = a; updi = d;
        cpu_q.push_back('{is_rd: 1'b0, rg: int'(a), data: 32'd0, cyc: cyc});
        step();
        upen = 1'b0; upws = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, input logic [31:0] exp);
        upen = 1'b1; uprs = 1'b1; upa = a;
        cpu_q.push_back('{is_rd: 1'b1, rg: int'(a), data: exp, cyc: cyc});
        step();
        upen = 1'b0; uprs = 1'b0;
    endtask

    task automatic sample(input logic [31:0] d, input logic wr, input logic [DBADD-1:0] addr);
        vld = 1'b1; dat = d;
        if (wr) cap_q.push_back('{addr: addr, data: d});
        step();
        vld = 1'b0;
    endtask

    initial begin
        // Reset held with the sample stream toggling.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vld = ~vld; dat = 32'(i + 1);
            @(negedge clk);
            check("reset_cap_we", {31'd0, cap_we}, 32'd0);
            check("reset_uprdy", {31'd0, uprdy}, 32'd0);
        end
        @(posedge clk); #1;
        vld  = 1'b0;
        rst_ = 1'b1;
        step();

        // Register access after reset.
        cpu_read(3'd1, 32'h0);
        cpu_read(3'd3, 32'h0);
        cpu_write(3'd2, 32'hA5A5_0001);
        cpu_read(3'd2, 32'hA5A5_0001);
        cpu_write(3'd7, 32'hFFFF_FFFF);
        cpu_read(3'd7, 32'h0);

        // Immediate mode, POSTCNT=3: four writes at 0..3.
        cpu_write(3'd4, 32'd3);
        cpu_write(3'd0, 32'h1);
        cpu_read(3'd1, 32'hA);              // POST, TRIGGERED
        for (int i = 0; i < 4; i++) sample(32'(10 + i), 1'b1, DBADD'(i));
        sample(32'd99, 1'b0, '0);           // DONE: not written
        step();
        cpu_read(3'd1, 32'hB);              // DONE, TRIGGERED
        cpu_read(3'd6, 32'd4);
        cpu_read(3'd5, 32'd0);
        cpu_read(3'd0, 32'h0);

        // Pattern trigger at 0x55, two post samples.
        cpu_write(3'd2, 32'h55);
        cpu_write(3'd3, 32'hFF);
        cpu_write(3'd4, 32'd2);
        cpu_write(3'd0, 32'h3);
        cpu_read(3'd0, 32'h2);
        cpu_read(3'd1, 32'h1);              // PRE
        for (int i = 0; i < 32'h60; i++) sample(32'(i), i <= 32'h57, DBADD'(i));
        step();
        cpu_read(3'd1, 32'hB);
        cpu_read(3'd5, 32'h55);
        cpu_read(3'd6, 32'h58);

        // Wrap while waiting for the trigger, then trigger at address 4.
        cpu_write(3'd4, 32'd0);
        cpu_write(3'd0, 32'h3);
        for (int i = 0; i < 2052; i++) sample(32'(i % 64), 1'b1, DBADD'(i % 2048));
        step();
        cpu_read(3'd1, 32'h5);              // PRE, WRAPPED
        cpu_read(3'd6, 32'd4);
        sample(32'h55, 1'b1, DBADD'(4));
        step();
        cpu_read(3'd1, 32'hF);              // DONE, WRAPPED, TRIGGERED
        cpu_read(3'd5, 32'd4);
        cpu_read(3'd6, 32'd5);

        // Re-arm in PRE, trigger, then abort in POST.
        cpu_write(3'd4, 32'd5);
        cpu_write(3'd0, 32'h3);
        sample(32'h01, 1'b1, DBADD'(0));
        sample(32'h02, 1'b1, DBADD'(1));
        cpu_write(3'd0, 32'h3);
        cpu_read(3'd6, 32'd0);
        cpu_read(3'd1, 32'h1);
        sample(32'h155, 1'b1, DBADD'(0));   // masked match
        sample(32'h07, 1'b1, DBADD'(1));
        cpu_read(3'd1, 32'hA);              // POST, TRIGGERED
        cpu_write(3'd0, 32'h4);
        cpu_read(3'd1, 32'h8);              // IDLE, TRIGGERED kept
        sample(32'h08, 1'b0, '0);
        sample(32'h55, 1'b0, '0);
        cpu_write(3'd0, 32'h5);             // ARM+ABORT: abort wins
        cpu_read(3'd1, 32'h8);
        cpu_read(3'd6, 32'd2);
        check("busy_idle", {31'd0, cap_busy}, 32'd0);

        // Asynchronous reset in the middle of POST.
        cpu_write(3'd4, 32'd10);
        cpu_write(3'd0, 32'h1);
        for (int i = 0; i < 3; i++) sample(32'(32'h30 + i), 1'b1, DBADD'(i));
        cpu_read(3'd3, 32'hFF);
        step();
        check("busy_post", {31'd0, cap_busy}, 32'd1);
        #2;
        rst_ = 1'b0;
        #1;
        check("async_busy", {31'd0, cap_busy}, 32'd0);
        check("async_wa", {21'd0, cap_wa}, 32'd0);
        check("async_wd", cap_wd, 32'd0);
        check("async_updo", updo, 32'd0);
        check("async_we", {31'd0, cap_we}, 32'd0);
        step();
        step();
        rst_ = 1'b1;
        step();
        cpu_read(3'd1, 32'h0);
        cpu_read(3'd3, 32'h0);
        cpu_read(3'd6, 32'h0);

        step();
        step();
        check("cpu_queue_empty", cpu_q.size(), 32'd0);
        check("cap_queue_empty", cap_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dump_trig_ctrl.md
Name: dump_trig_ctrl

Overview:
- Trigger/sequencing controller for the debug dump capture buffer (DBADD-bit address, DBDAT-bit data RAM behind the CPU-readable dump array).
- Replaces free-running "fill until full" dumping with arm / pre-trigger / post-trigger capture: samples circulate in the buffer until a pattern match, then a programmed number of post-trigger samples is written and capture stops.
- Supplies buffer write strobes and addresses, and exposes config/status registers on the standard up* CPU bus.

Parameters:
- DBADD, 11, capture buffer address width; buffer depth 2^DBADD.
- DBDAT, 32, sample width; also CPU data width. Must be ≥ DBADD+4.

Ports:
- clk, in, 1, system clock.
- rst_, in, 1, asynchronous active-low reset.
- vld, in, 1, sample valid.
- dat, in, DBDAT, sample data.
- cap_we, out, 1, buffer write enable.
- cap_wa, out, DBADD, buffer write address.
- cap_wd, out, DBDAT, buffer write data.
- cap_busy, out, 1, high in PRE or POST.
- upen, in, 1, CPU select.
- upa, in, 3, CPU register address.
- upws, in, 1, CPU write strobe.
- uprs, in, 1, CPU read strobe.
- updi, in, DBDAT, CPU write data.
- updo, out, DBDAT, CPU read data.
- uprdy, out, 1, CPU ready.

Behaviour:
- Reset (rst_ low, asynchronous): state IDLE; cap_we=0, cap_wa=0, cap_wd=0, cap_busy=0, updo=0, uprdy=0; all registers 0, except MASK=0 (match-all).
- Registers (upa):
  - 0 CTRL (W): bit0 ARM (self-clearing pulse); bit1 MODE (0 = immediate, 1 = pattern trigger); bit2 ABORT (pulse). Read returns MODE in bit1, other bits 0.
  - 1 STAT (R): [1:0] state (IDLE=0, PRE=1, POST=2, DONE=3); bit2 WRAPPED; bit3 TRIGGERED.
  - 2 PATTERN (RW).
  - 3 MASK (RW).
  - 4 POSTCNT (RW, low DBADD bits used).
  - 5 TRIGADDR (R).
  - 6 WRPTR (R).
  - 7 reads 0, writes ignored.
- CPU access:
  - An access is upen & (upws|uprs). uprdy pulses exactly 1 cycle, the cycle after the access.
  - updo is valid with uprdy and holds until the next read.
  - upws and uprs together are treated as a write.
- Write pointer: wrptr is a DBADD-bit counter.
  - Increments on each capture write; wraps from 2^DBADD-1 to 0 and sets WRAPPED.
  - ARM clears wrptr, WRAPPED, TRIGGERED and TRIGADDR.
- Capture (registered, 1-cycle latency): in PRE or POST, vld=1 at cycle n gives cap_we=1, cap_wa=wrptr, cap_wd=dat at cycle n+1. Otherwise cap_we=0 and cap_wa/cap_wd hold.
- Match condition: vld & (((dat ^ PATTERN) & MASK) == 0).
- State transitions:
  - IDLE/DONE + ARM: MODE=1 → PRE; MODE=0 → POST with TRIGGERED=1 and TRIGADDR=0.
  - PRE: on a match sample, that sample is written, TRIGADDR = its address, TRIGGERED=1, postcnt loaded with POSTCNT → POST.
  - POST: each written vld sample decrements postcnt. When postcnt==0 at trigger time, or at the decrement to 0, → DONE. The trigger sample itself is not counted.
  - Immediate mode: POSTCNT+1 samples are written starting at address 0; POSTCNT=0 writes 1 sample.
  - DONE: no writes. STAT stays readable.
- Simultaneous and corner events:
  - ABORT in any state → IDLE next cycle; a capture write already registered still completes; TRIGGERED/TRIGADDR are retained.
  - ARM and ABORT in the same write: ABORT wins.
  - ARM in PRE or POST restarts capture: counters are cleared as for a fresh arm.
  - PATTERN/MASK/POSTCNT writes take effect the next cycle. POSTCNT written in POST does not alter the running postcnt.
  - Match and wrap in the same sample: both recorded.
- cap_busy = (state==PRE)|(state==POST), registered with the state.

Test Plan:
- Reset with vld toggling → cap_we=0, STAT=0, uprdy=0. Write then read PATTERN=0xA5A5_0001 → uprdy 1 cycle after each strobe, updo=0xA5A50001.
- MODE=0, POSTCNT=3, ARM, 4 continuous vld samples 10..13 → cap_we 4 cycles at addresses 0..3 with data 10..13; STAT=DONE with TRIGGERED=1; WRPTR=4.
- MODE=1, PATTERN=0x55, MASK=0xFF, POSTCNT=2, ARM, stream 0x00..0x5F → trigger at sample 0x55, TRIGADDR=0x55; last write data 0x57 at address 0x57; STAT=DONE.
- MODE=1, DBADD=4, no match for 20 samples → wrptr wraps, WRAPPED=1, state PRE; then match → TRIGADDR=4.
- ARM in PRE, then ABORT while in POST → state IDLE, no further cap_we. CTRL=0x5 (ARM+ABORT) from IDLE → stays IDLE.
- Assert rst_ low mid-POST asynchronously → outputs 0 immediately, STAT=0 after release.
